// File: rtl/regfile_wb_arbiter.sv
// Single register-file write port shared by pipeline writeback, the multicycle unit and debug,
// plus the MC destination scoreboard. Define WBARB_DBG_EN to enable the debug write port.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 16,
    parameter int REG_AW       = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_write,
    input  logic [REG_AW-1:0] pipe_writenum,
    input  logic [DATA_W-1:0] pipe_wdata,
    input  logic              mc_valid,
    input  logic [REG_AW-1:0] mc_writenum,
    input  logic [DATA_W-1:0] mc_wdata,
    output logic              mc_ready,
    input  logic              mc_issue_valid,
    input  logic [REG_AW-1:0] mc_issue_num,
    output logic              mc_issue_ready,
    input  logic              dbg_valid,
    input  logic [REG_AW-1:0] dbg_writenum,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    input  logic [REG_AW-1:0] rd_num_a,
    input  logic [REG_AW-1:0] rd_num_b,
    output logic              hazard_out,
    output logic              stall_req,
    output logic              rf_write,
    output logic [REG_AW-1:0] rf_writenum,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_conflict
);

    localparam int NREG  = 1 << REG_AW;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [NREG-1:0]   r_busy;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_stall_req;
    logic              r_rf_write;
    logic [REG_AW-1:0] r_rf_writenum;
    logic [DATA_W-1:0] r_rf_wdata;
    logic              r_wb_conflict;

    logic              w_dbg_req;
    logic              w_favour_mc;
    logic              w_grant_mc;
    logic              w_grant_dbg;
    logic              w_any_grant;
    logic              w_issue_acc;
    logic [CNT_W-1:0]  w_starve_nxt;
    logic [NREG-1:0]   w_busy_nxt;

`ifdef WBARB_DBG_EN
    logic r_rr_mc;

    assign w_dbg_req   = dbg_valid;
    assign w_favour_mc = r_rr_mc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_mc <= 1'b1;
        end else if (w_any_grant) begin
            r_rr_mc <= !r_rr_mc;
        end
    end
`else
    logic w_unused_dbg;

    assign w_dbg_req    = 1'b0;
    assign w_favour_mc  = 1'b1;
    assign w_unused_dbg = ^{dbg_valid, dbg_writenum, dbg_wdata};
`endif

    // Pipeline owns the slot outright; MC/DBG only see cycles it leaves idle.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        w_grant_mc  = 1'b0;
        w_grant_dbg = 1'b0;
        if (!pipe_write) begin
            if (mc_valid && (w_favour_mc || !w_dbg_req)) begin
                w_grant_mc = 1'b1;
            end else if (w_dbg_req) begin
                w_grant_dbg = 1'b1;
            end
        end
    end

    assign w_any_grant    = w_grant_mc | w_grant_dbg;
    assign mc_issue_ready = !r_busy[mc_issue_num];
    assign w_issue_acc    = mc_issue_valid && mc_issue_ready;

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_any_grant) begin
            w_starve_nxt = '0;
        end else if ((mc_valid || w_dbg_req) && (r_starve_cnt != CNT_MAX)) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
    end

    // Clear first, then set, so a same-cycle issue to the retiring register keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_grant_mc) begin
            w_busy_nxt[mc_writenum] = 1'b0;
        end
        if (w_issue_acc) begin
            w_busy_nxt[mc_issue_num] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            // NOTE: the busy array is control state, not data storage, so it must be cleared on reset.
            r_busy        <= '0;
            r_starve_cnt  <= '0;
            r_stall_req   <= 1'b0;
            r_rf_write    <= 1'b0;
            r_rf_writenum <= '0;
            r_rf_wdata    <= '0;
            r_wb_conflict <= 1'b0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_stall_req  <= (w_starve_nxt == CNT_MAX);
            if (pipe_write && r_busy[pipe_writenum]) begin
                r_wb_conflict <= 1'b1;
            end
            r_rf_write <= pipe_write | w_any_grant;
            if (pipe_write) begin
                r_rf_writenum <= pipe_writenum;
                r_rf_wdata    <= pipe_wdata;
            end else if (w_grant_mc) begin
                r_rf_writenum <= mc_writenum;
                r_rf_wdata    <= mc_wdata;
            end else if (w_grant_dbg) begin
                r_rf_writenum <= dbg_writenum;
                r_rf_wdata    <= dbg_wdata;
            end
        end
    end

    assign mc_ready    = w_grant_mc;
    assign dbg_ready   = w_grant_dbg;
    assign hazard_out  = r_busy[rd_num_a] | r_busy[rd_num_b];
    assign stall_req   = r_stall_req;
    assign rf_write    = r_rf_write;
    assign rf_writenum = r_rf_writenum;
    assign rf_wdata    = r_rf_wdata;
    assign wb_conflict = r_wb_conflict;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a behavioural model of
// the write-port rules; honours WBARB_DBG_EN the same way as the design.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int NREG   = 8;
    localparam int LIMIT  = 4;
`ifdef WBARB_DBG_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              pipe_write;
    logic [REG_AW-1:0] pipe_writenum;
    logic [DATA_W-1:0] pipe_wdata;
    logic              mc_valid;
    logic [REG_AW-1:0] mc_writenum;
    logic [DATA_W-1:0] mc_wdata;
    logic              mc_ready;
    logic              mc_issue_valid;
    logic [REG_AW-1:0] mc_issue_num;
    logic              mc_issue_ready;
    logic              dbg_valid;
    logic [REG_AW-1:0] dbg_writenum;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ready;
    logic [REG_AW-1:0] rd_num_a;
    logic [REG_AW-1:0] rd_num_b;
    logic              hazard_out;
    logic              stall_req;
    logic              rf_write;
    logic [REG_AW-1:0] rf_writenum;
    logic [DATA_W-1:0] rf_wdata;
    logic              wb_conflict;

    int total = 0;
    int bad   = 0;

    // Reference model: which registers await an MC result, how long MC/DBG has waited,
    // whose turn it is, and what the write port should show.
    bit              m_busy [NREG];
    int              m_wait;
    bit              m_turn_mc;
    logic            m_rf_write;
    logic [REG_AW-1:0] m_rf_num;
    logic [DATA_W-1:0] m_rf_data;
    bit              m_conflict;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .REG_AW(REG_AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_write(pipe_write), .pipe_writenum(pipe_writenum), .pipe_wdata(pipe_wdata),
        .mc_valid(mc_valid), .mc_writenum(mc_writenum), .mc_wdata(mc_wdata), .mc_ready(mc_ready),
        .mc_issue_valid(mc_issue_valid), .mc_issue_num(mc_issue_num), .mc_issue_ready(mc_issue_ready),
        .dbg_valid(dbg_valid), .dbg_writenum(dbg_writenum), .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
        .rd_num_a(rd_num_a), .rd_num_b(rd_num_b), .hazard_out(hazard_out),
        .stall_req(stall_req), .rf_write(rf_write), .rf_writenum(rf_writenum),
        .rf_wdata(rf_wdata), .wb_conflict(wb_conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; pipe_write = 0; pipe_writenum = 0; pipe_wdata = 0;
        mc_valid = 0; mc_writenum = 0; mc_wdata = 0;
        mc_issue_valid = 0; mc_issue_num = 0;
        dbg_valid = 0; dbg_writenum = 0; dbg_wdata = 0;
        rd_num_a = 0; rd_num_b = 0;
    endtask

    // One clock: check handshakes before the edge, advance the model, check the port after it.
    task automatic step();
        bit dbg_req, win_mc, win_dbg, can_issue;
        #2;
        dbg_req   = DBG_EN && dbg_valid;
        win_mc    = !pipe_write && mc_valid && (m_turn_mc || !dbg_req);
        win_dbg   = !pipe_write && dbg_req && !win_mc;
        can_issue = !m_busy[mc_issue_num];
        if (!rst) begin
            check("mc_ready", mc_ready, win_mc);
            check("dbg_ready", dbg_ready, win_dbg);
            check("mc_issue_ready", mc_issue_ready, can_issue);
            check("hazard_out", hazard_out, m_busy[rd_num_a] | m_busy[rd_num_b]);
        end
        @(posedge clk);
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_wait = 0; m_turn_mc = 1; m_conflict = 0;
            m_rf_write = 0; m_rf_num = 0; m_rf_data = 0;
        end else begin
            if (pipe_write && m_busy[pipe_writenum]) m_conflict = 1;
            if (win_mc) m_busy[mc_writenum] = 0;
            if (mc_issue_valid && can_issue) m_busy[mc_issue_num] = 1;
            if (win_mc || win_dbg) begin
                m_wait = 0;
                m_turn_mc = !m_turn_mc;
            end else if ((mc_valid || dbg_req) && m_wait < LIMIT) begin
                m_wait++;
            end
            m_rf_write = pipe_write || win_mc || win_dbg;
            if (pipe_write) begin
                m_rf_num = pipe_writenum; m_rf_data = pipe_wdata;
            end else if (win_mc) begin
                m_rf_num = mc_writenum; m_rf_data = mc_wdata;
            end else if (win_dbg) begin
                m_rf_num = dbg_writenum; m_rf_data = dbg_wdata;
            end
        end
        #1;
        check("rf_write", rf_write, m_rf_write);
        check("rf_writenum", rf_writenum, m_rf_num);
        check("rf_wdata", rf_wdata, m_rf_data);
        check("stall_req", stall_req, m_wait == LIMIT);
        check("wb_conflict", wb_conflict, m_conflict);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        m_wait = 0; m_turn_mc = 1; m_conflict = 0;
        m_rf_write = 0; m_rf_num = 0; m_rf_data = 0;
        foreach (m_busy[i]) m_busy[i] = 0;

        // Reset, then a plain pipeline write.
        do_reset();
        check("t1_reset_rf_write", rf_write, 1'b0);
        check("t1_reset_stall", stall_req, 1'b0);
        pipe_write = 1; pipe_writenum = 3; pipe_wdata = 16'h1234;
        step();
        check("t1_rf_write", rf_write, 1'b1);
        check("t1_rf_writenum", rf_writenum, 3);
        check("t1_rf_wdata", rf_wdata, 16'h1234);
        check("t1_conflict", wb_conflict, 1'b0);

`ifdef WBARB_DBG_EN
        // MC and DBG both held: grants alternate starting with MC.
        do_reset();
        mc_valid = 1; mc_writenum = 1; mc_wdata = 16'hAAAA;
        dbg_valid = 1; dbg_writenum = 6; dbg_wdata = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("t2_mc_alt", mc_ready, (i % 2) == 0);
            check("t2_dbg_alt", dbg_ready, (i % 2) == 1);
            step();
        end
        idle();
`endif

        // Starvation under continuous pipeline writes.
        do_reset();
        pipe_write = 1; pipe_writenum = 0; mc_valid = 1; mc_writenum = 7; mc_wdata = 16'hBEEF;
        for (int i = 1; i <= LIMIT; i++) begin
            pipe_wdata = 16'(i);
            step();
            check("t3_stall_rise", stall_req, i == LIMIT);
        end
        pipe_write = 0;
        #2;
        check("t3_mc_ready", mc_ready, 1'b1);
        step();
        check("t3_stall_clear", stall_req, 1'b0);
        check("t3_mc_data", rf_wdata, 16'hBEEF);
        idle();

        // Scoreboard hazard on r5.
        mc_issue_valid = 1; mc_issue_num = 5;
        step();
        rd_num_a = 5;
        #2;
        check("t4_hazard_set", hazard_out, 1'b1);
        check("t4_reissue_blocked", mc_issue_ready, 1'b0);
        step();
        mc_issue_valid = 0; mc_valid = 1; mc_writenum = 5; mc_wdata = 16'h0F0F;
        step();
        mc_valid = 0;
        #2;
        check("t4_hazard_clear", hazard_out, 1'b0);
        step();
        idle();

        // Same-cycle retire and issue of r2: issue wins, then a pipe write to r2 conflicts.
        mc_valid = 1; mc_writenum = 2; mc_wdata = 16'h2222;
        mc_issue_valid = 1; mc_issue_num = 2;
        step();
        idle();
        rd_num_b = 2;
        #2;
        check("t5_busy_kept", hazard_out, 1'b1);
        pipe_write = 1; pipe_writenum = 2; pipe_wdata = 16'h9999;
        step();
        check("t5_conflict", wb_conflict, 1'b1);
        check("t5_write_done", rf_wdata, 16'h9999);
        idle();
        for (int i = 0; i < 3; i++) step();
        check("t5_conflict_sticky", wb_conflict, 1'b1);

        // Reset with MC pending and r4 busy.
        mc_issue_valid = 1; mc_issue_num = 4;
        step();
        idle();
        mc_valid = 1; mc_writenum = 4; mc_wdata = 16'h4444;
        rst = 1;
        step();
        idle();
        rd_num_a = 4; rd_num_b = 2;
        #2;
        check("t6_sb_empty", hazard_out, 1'b0);
        step();
        check("t6_no_write", rf_write, 1'b0);
        check("t6_conflict_clear", wb_conflict, 1'b0);

        // Randomized traffic; the pipeline honours stall_req by bubbling.
        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(0, 79) == 0);
            pipe_write     = (m_wait == LIMIT) ? 1'b0 : ($urandom_range(0, 1) == 1);
            pipe_writenum  = REG_AW'($urandom);
            pipe_wdata     = DATA_W'($urandom);
            mc_valid       = ($urandom_range(0, 2) != 0);
            mc_writenum    = REG_AW'($urandom);
            mc_wdata       = DATA_W'($urandom);
            mc_issue_valid = ($urandom_range(0, 2) == 0);
            mc_issue_num   = REG_AW'($urandom);
            dbg_valid      = ($urandom_range(0, 1) == 1);
            dbg_writenum   = REG_AW'($urandom);
            dbg_wdata      = DATA_W'($urandom);
            rd_num_a       = REG_AW'($urandom);
            rd_num_b       = REG_AW'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
